// File: rtl/debug_unit_if.sv
// Signal bundle between debug_unit and its host-side peers
// (UART rx/tx, pipeline control, instruction-memory write port).
interface debug_unit_if #(
   parameter int ADDR_BITS  = 32,
   parameter int DATA_WIDTH = 32
);
   logic [7:0]            rx_data;
   logic                  rx_done;
   logic                  tx_done;
   logic                  halt;
   logic [ADDR_BITS-1:0]  pc_value;
   logic [7:0]            tx_data;
   logic                  tx_start;
   logic                  imem_wr_en;
   logic [ADDR_BITS-1:0]  imem_addr;
   logic [DATA_WIDTH-1:0] imem_wr_data;
   logic                  pc_enable;
   logic                  pc_reset;

   modport master (
      output rx_data, rx_done, tx_done, halt, pc_value,
      input  tx_data, tx_start, imem_wr_en, imem_addr,
      input  imem_wr_data, pc_enable, pc_reset
   );

   modport slave (
      input  rx_data, rx_done, tx_done, halt, pc_value,
      output tx_data, tx_start, imem_wr_en, imem_addr,
      output imem_wr_data, pc_enable, pc_reset
   );
endinterface

// File: rtl/debug_unit.sv
// UART debug controller: loads imem, runs/steps the pipeline,
// and reports PC and executed-cycle count over the transmitter.
module debug_unit #(
   parameter int ADDR_BITS  = 32,
   parameter int DATA_WIDTH = 32
) (
   input logic         clk,
   input logic         reset,
   debug_unit_if.slave bus
);
   typedef enum logic [3:0] {
      S_IDLE, S_LOAD_LEN, S_LOAD_BYTE, S_LOAD_WRITE,
      S_RUN, S_STEP, S_PCRST, S_SEND, S_WAIT_TX
   } state_t;

   localparam logic [7:0] CMD_L = 8'h4C;
   localparam logic [7:0] CMD_C = 8'h43;
   localparam logic [7:0] CMD_S = 8'h53;
   localparam logic [7:0] CMD_R = 8'h52;

   state_t                r_state;
   state_t                w_next;
   logic [7:0]            r_len;
   logic [7:0]            r_widx;
   logic [7:0]            w_widx_nxt;
   logic [1:0]            r_bcnt;
   logic [23:0]           r_word;
   logic [31:0]           r_cycles;
   logic [31:0]           w_cyc_nxt;
   logic [63:0]           r_buf;
   logic [2:0]            r_txleft;
   logic [ADDR_BITS-1:0]  r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [31:0]           w_pc32;
   logic                  w_pc_en;
   logic                  w_tx_start;
   logic                  w_wr_en;
   logic                  w_pc_rst;
   logic [7:0]            w_tx_data;

   assign w_pc32     = 32'(bus.pc_value);
   assign w_widx_nxt = r_widx + 8'd1;
   assign w_cyc_nxt  = r_cycles + {31'd0, w_pc_en};

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // halt at decode skips RUN/STEP and goes straight to the report
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (bus.rx_done) begin
               case (bus.rx_data)
                  CMD_L:   w_next = S_LOAD_LEN;
                  CMD_C:   w_next = bus.halt ? S_SEND : S_RUN;
                  CMD_S:   w_next = bus.halt ? S_SEND : S_STEP;
                  CMD_R:   w_next = S_PCRST;
                  default: w_next = S_IDLE;
               endcase
            end
         end
         S_LOAD_LEN: begin
            if (bus.rx_done)
               w_next = (bus.rx_data == 8'd0) ? S_SEND : S_LOAD_BYTE;
         end
         S_LOAD_BYTE: begin
            if (bus.rx_done && r_bcnt == 2'd3) w_next = S_LOAD_WRITE;
         end
         S_LOAD_WRITE: begin
            w_next = (w_widx_nxt == r_len) ? S_SEND : S_LOAD_BYTE;
         end
         S_RUN: begin
            if (bus.halt) w_next = S_SEND;
         end
         S_STEP:  w_next = S_SEND;
         S_PCRST: w_next = S_SEND;
         S_SEND:  w_next = S_WAIT_TX;
         S_WAIT_TX: begin
            if (bus.tx_done)
               w_next = (r_txleft == 3'd0) ? S_IDLE : S_SEND;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_pc_en    = (r_state == S_RUN) || (r_state == S_STEP);
      w_tx_start = (r_state == S_SEND);
      w_wr_en    = (r_state == S_LOAD_WRITE);
      w_pc_rst   = (r_state == S_PCRST);
      w_tx_data  = 8'h00;
      if (r_state == S_SEND || r_state == S_WAIT_TX)
         w_tx_data = r_buf[63:56];
   end

   // r_buf holds the outgoing message, MSB byte first
   always_ff @(posedge clk) begin
      if (reset) begin
         r_len    <= '0;
         r_widx   <= '0;
         r_bcnt   <= '0;
         r_word   <= '0;
         r_cycles <= '0;
         r_buf    <= '0;
         r_txleft <= '0;
         r_addr   <= '0;
         r_wdata  <= '0;
      end else begin
         r_cycles <= (r_state == S_PCRST) ? 32'd0 : w_cyc_nxt;
         unique case (r_state)
            S_IDLE: begin
               if (bus.rx_done) begin
                  if (bus.rx_data == CMD_R) begin
                     r_buf    <= {CMD_R, 56'd0};
                     r_txleft <= 3'd0;
                  end else begin
                     r_buf    <= {w_pc32, r_cycles};
                     r_txleft <= 3'd7;
                  end
               end
            end
            S_LOAD_LEN: begin
               if (bus.rx_done) begin
                  r_len    <= bus.rx_data;
                  r_widx   <= '0;
                  r_bcnt   <= '0;
                  r_buf    <= {CMD_L, 56'd0};
                  r_txleft <= 3'd0;
               end
            end
            S_LOAD_BYTE: begin
               if (bus.rx_done) begin
                  r_bcnt <= r_bcnt + 2'd1;
                  r_word <= {r_word[15:0], bus.rx_data};
                  if (r_bcnt == 2'd3) begin
                     r_addr  <= ADDR_BITS'({r_widx, 2'b00});
                     r_wdata <= DATA_WIDTH'({r_word, bus.rx_data});
                  end
               end
            end
            S_LOAD_WRITE: r_widx <= w_widx_nxt;
            S_RUN: begin
               if (bus.halt) begin
                  r_buf    <= {w_pc32, w_cyc_nxt};
                  r_txleft <= 3'd7;
               end
            end
            S_STEP: begin
               r_buf    <= {w_pc32, w_cyc_nxt};
               r_txleft <= 3'd7;
            end
            S_WAIT_TX: begin
               if (bus.tx_done && r_txleft != 3'd0) begin
                  r_buf    <= {r_buf[55:0], 8'h00};
                  r_txleft <= r_txleft - 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.pc_enable    = w_pc_en;
   assign bus.pc_reset     = w_pc_rst;
   assign bus.tx_start     = w_tx_start;
   assign bus.tx_data      = w_tx_data;
   assign bus.imem_wr_en   = w_wr_en;
   assign bus.imem_addr    = r_addr;
   assign bus.imem_wr_data = r_wdata;
endmodule

// File: tb/tb_debug_unit.sv
// Self-checking bench for debug_unit: scoreboarded tx bytes and
// imem writes, table-driven step vectors, hand-written corner cases.
module tb_debug_unit;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   debug_unit_if #(.ADDR_BITS(32), .DATA_WIDTH(32)) bus ();

   debug_unit #(.ADDR_BITS(32), .DATA_WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      logic [31:0] pc;
      logic        halt;
      int          en;
   } step_t;

   logic [7:0]  exp_tx[$];
   wr_t         exp_wr[$];
   wr_t         mw;
   logic [7:0]  rb;
   logic [31:0] m_cycles;
   int n_cmp = 0;
   int n_bad = 0;
   int n_en = 0;
   int n_rst = 0;
   int n_tx = 0;
   int n_wr = 0;
   bit tx_busy = 1'b0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (bus.pc_enable) n_en++;
         if (bus.pc_reset) n_rst++;
         if (bus.imem_wr_en) begin
            n_wr++;
            if (exp_wr.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_wr: got addr %0h required none",
                        bus.imem_addr);
            end else begin
               mw = exp_wr.pop_front();
               chk("wr_addr", 64'(bus.imem_addr), 64'(mw.addr));
               chk("wr_data", 64'(bus.imem_wr_data), 64'(mw.data));
            end
         end
      end
   end

   // transmitter model: answers every tx_start with a late tx_done
   initial begin
      bus.tx_done = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.tx_start && !reset) begin
            n_tx++;
            tx_busy = 1'b1;
            if (exp_tx.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_tx: got %02h required none",
                        bus.tx_data);
               rb = bus.tx_data;
            end else begin
               rb = exp_tx.pop_front();
               chk("tx_byte", 64'(bus.tx_data), 64'(rb));
            end
            @(negedge clk);
            chk("tx_start_pulse", 64'(bus.tx_start), 64'd0);
            @(posedge clk);
            #1;
            chk("tx_hold", 64'(bus.tx_data), 64'(rb));
            bus.tx_done = 1'b1;
            @(posedge clk);
            #1;
            bus.tx_done = 1'b0;
            tx_busy = 1'b0;
         end
      end
   end

   task automatic send(input logic [7:0] b);
      @(posedge clk);
      #1;
      bus.rx_data = b;
      bus.rx_done = 1'b1;
      @(posedge clk);
      #1;
      bus.rx_done = 1'b0;
   endtask

   task automatic push_report(input logic [31:0] pc,
                              input logic [31:0] cnt);
      logic [63:0] v;
      v = {pc, cnt};
      for (int i = 7; i >= 0; i--) exp_tx.push_back(v[i*8 +: 8]);
   endtask

   task automatic wait_tx(input string name);
      int g;
      g = 0;
      while ((exp_tx.size() != 0 || tx_busy) && g < 3000) begin
         @(posedge clk);
         g++;
      end
      if (g >= 3000) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_timeout: got %0d bytes pending required 0",
                  name, exp_tx.size());
         exp_tx.delete();
      end
      repeat (3) @(posedge clk);
      #1;
      chk({name, "_idle"},
          {61'd0, bus.tx_start, bus.pc_enable, bus.pc_reset}, 64'd0);
   endtask

   task automatic do_step(input logic [31:0] pc, input logic h,
                          input int en);
      int e0;
      bus.pc_value = pc;
      bus.halt = h;
      if (!h) m_cycles = m_cycles + 32'd1;
      push_report(pc, m_cycles);
      e0 = n_en;
      send(8'h53);
      wait_tx("step");
      chk("step_en_cycles", 64'(n_en - e0), 64'(en));
      bus.halt = 1'b0;
   endtask

   task automatic chk_zero_outs(input string name);
      chk({name, "_tx"}, {55'd0, bus.tx_data, bus.tx_start}, 64'd0);
      chk({name, "_addr"}, 64'(bus.imem_addr), 64'd0);
      chk({name, "_data"}, 64'(bus.imem_wr_data), 64'd0);
      chk({name, "_ctl"},
          {61'd0, bus.imem_wr_en, bus.pc_enable, bus.pc_reset}, 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish required finish");
      $fatal(1, "watchdog");
   end

   step_t sv[4];
   int w0, e0, r0, t0, g;

   initial begin
      sv[0] = '{32'h00000008, 1'b0, 1};
      sv[1] = '{32'h12345678, 1'b0, 1};
      sv[2] = '{32'hDEADBEEF, 1'b1, 0};
      sv[3] = '{32'hFFFFFFFC, 1'b0, 1};

      reset = 1'b1;
      bus.rx_data = 8'h00;
      bus.rx_done = 1'b0;
      bus.halt = 1'b0;
      bus.pc_value = '0;
      m_cycles = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      chk_zero_outs("reset");
      reset = 1'b0;

      // load two words
      exp_wr.push_back('{32'h0, 32'h20010005});
      exp_wr.push_back('{32'h4, 32'h20020007});
      exp_tx.push_back(8'h4C);
      w0 = n_wr;
      send(8'h4C);
      send(8'd2);
      send(8'h20); send(8'h01); send(8'h00); send(8'h05);
      send(8'h20); send(8'h02); send(8'h00); send(8'h07);
      wait_tx("load");
      chk("load_writes", 64'(n_wr - w0), 64'd2);
      chk("load_addr_hold", 64'(bus.imem_addr), 64'h4);
      chk("load_data_hold", 64'(bus.imem_wr_data), 64'h20020007);

      do_step(32'h00000008, 1'b0, 1);

      // run: halt sampled at the edge ending the 10th enabled cycle
      bus.pc_value = 32'h00000020;
      push_report(32'h00000020, m_cycles + 32'd10);
      m_cycles = m_cycles + 32'd10;
      e0 = n_en;
      send(8'h43);
      chk("run_start", 64'(bus.pc_enable), 64'd1);
      g = 0;
      while (!bus.pc_enable && g < 20) begin
         @(negedge clk);
         g++;
      end
      repeat (9) @(posedge clk);
      #1;
      bus.halt = 1'b1;
      wait_tx("run");
      bus.halt = 1'b0;
      chk("run_en_cycles", 64'(n_en - e0), 64'd10);

      // run with halt already high
      bus.pc_value = 32'h00000044;
      bus.halt = 1'b1;
      push_report(32'h00000044, m_cycles);
      e0 = n_en;
      send(8'h43);
      wait_tx("run_halted");
      bus.halt = 1'b0;
      chk("run_halted_en", 64'(n_en - e0), 64'd0);

      // pipeline reset
      exp_tx.push_back(8'h52);
      r0 = n_rst;
      send(8'h52);
      chk("pcrst_now", 64'(bus.pc_reset), 64'd1);
      wait_tx("pcrst");
      chk("pcrst_pulses", 64'(n_rst - r0), 64'd1);
      m_cycles = 32'd0;

      for (int i = 0; i < 4; i++) do_step(sv[i].pc, sv[i].halt, sv[i].en);

      // unknown command byte
      t0 = n_tx; w0 = n_wr; e0 = n_en; r0 = n_rst;
      send(8'h7A);
      repeat (6) @(posedge clk);
      chk("unk_tx", 64'(n_tx - t0), 64'd0);
      chk("unk_other", 64'((n_wr - w0) + (n_en - e0) + (n_rst - r0)),
          64'd0);
      do_step(32'h00000030, 1'b1, 0);

      // empty load
      exp_tx.push_back(8'h4C);
      w0 = n_wr;
      send(8'h4C);
      send(8'd0);
      wait_tx("load0");
      chk("load0_writes", 64'(n_wr - w0), 64'd0);

      // reset in the middle of a word
      send(8'h4C);
      send(8'd1);
      send(8'h11);
      send(8'h22);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk_zero_outs("midreset");
      reset = 1'b0;
      m_cycles = 32'd0;
      exp_wr.push_back('{32'h0, 32'hA1B2C3D4});
      exp_tx.push_back(8'h4C);
      w0 = n_wr;
      send(8'h4C);
      send(8'd1);
      send(8'hA1); send(8'hB2); send(8'hC3); send(8'hD4);
      wait_tx("reload");
      chk("reload_writes", 64'(n_wr - w0), 64'd1);
      do_step(32'h00000004, 1'b0, 1);

      chk("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/debug_unit.md
# debug_unit

UART-side controller that sits directly upstream of the pipeline top and drives its `pc_enable` / `pc_reset` inputs. It loads a program into instruction memory from received bytes, then runs the pipeline continuously or single-steps it. After each run or step it returns the current PC and the executed-cycle count through the UART transmitter.

## Interface
Parameters:
- ADDR_BITS, 32, width of PC and instruction-memory byte address
- DATA_WIDTH, 32, instruction word width (4 bytes)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  received UART byte
- rx_done  in  1  one-cycle pulse: rx_data valid
- tx_done  in  1  one-cycle pulse: transmitter finished the previous byte
- halt  in  1  pipeline retired HALT instruction (level)
- pc_value  in  ADDR_BITS  current PC from fetch stage
- tx_data  out  8  byte to transmit
- tx_start  out  1  one-cycle pulse: start sending tx_data
- imem_wr_en  out  1  one-cycle instruction-memory write strobe
- imem_addr  out  ADDR_BITS  byte address of the write
- imem_wr_data  out  DATA_WIDTH  instruction word to write
- pc_enable  out  1  pipeline advance enable
- pc_reset  out  1  one-cycle pipeline/PC reset pulse

## Operation
- Commands are the first byte received in IDLE:
  - 0x4C 'L': load.
  - 0x43 'C': continuous run.
  - 0x53 'S': step.
  - 0x52 'R': pipeline reset.
  - Any other byte is discarded and the unit stays in IDLE.
- States: IDLE, LOAD_LEN, LOAD_BYTE, LOAD_WRITE, RUN, STEP, PCRST, SEND, WAIT_TX.
- Load:
  - LOAD_LEN takes byte N, the word count (0–255).
  - LOAD_BYTE assembles 4 bytes per word, MSB first.
  - After the 4th byte, LOAD_WRITE pulses imem_wr_en for one cycle with imem_addr = word_index×4.
  - word_index increments; the unit returns to LOAD_BYTE until N words are written.
  - Then it sends ack 0x4C.
  - N=0: ack immediately, no writes.
- Run ('C'):
  - RUN holds pc_enable=1 every cycle.
  - A 32-bit cycle_count increments once per pc_enable=1 cycle and wraps at 2^32.
  - halt sampled 1 at a clock edge → leave RUN and send the report.
  - If halt=1 when 'C' is decoded, skip RUN and send the report with zero cycles added.
- Step ('S'):
  - STEP asserts pc_enable for exactly one cycle, cycle_count+1, then sends the report.
  - If halt=1, pc_enable is not asserted; the report is sent unchanged.
- Reset ('R'): PCRST pulses pc_reset for one cycle, clears cycle_count, then sends ack 0x52.
- Report is 8 bytes: pc_value latched at report start (4 bytes, MSB first), then cycle_count (4 bytes, MSB first).
- rx_done pulses received in any state other than IDLE, LOAD_LEN or LOAD_BYTE are ignored and lost.
- pc_enable is 0 in every state except RUN and STEP.

## Timing
- Reset values:
  - All outputs 0; tx_data=0x00.
  - state=IDLE, cycle_count=0, word_index=0, byte counter 0; any partial word is discarded.
- Reset asserted mid-operation (load, run, transmit) aborts immediately; the next edge yields IDLE with all outputs 0.
- Command decode: rx_done at edge k → new state visible at edge k+1.
  - 'C': pc_enable=1 from cycle k+1.
  - 'R': pc_reset=1 in cycle k+1 only.
- Load write: 4th byte's rx_done at edge k → imem_wr_en=1 during cycle k+1, with imem_addr and imem_wr_data stable in that cycle.
- RUN exit: halt=1 at edge k → pc_enable=0 from cycle k+1, so the last enabled cycle is k.
- Transmit handshake:
  - SEND drives tx_data and pulses tx_start for one cycle.
  - WAIT_TX holds tx_data until tx_done.
  - The next byte's tx_start comes the cycle after tx_done.
  - After the last byte's tx_done, return to IDLE.
  - tx_done outside WAIT_TX is ignored.
- imem_addr and imem_wr_data hold their last values between writes.

## Test plan
- Reset then load: 'L', N=2, bytes 20 01 00 05 20 02 00 07 → two imem_wr_en pulses: addr 0 data 0x20010005, then addr 4 data 0x20020007; then tx byte 0x4C.
- Step: PC=0x00000008, halt=0, send 'S' → pc_enable high exactly 1 cycle; tx bytes 00 00 00 08 00 00 00 01, each after the preceding tx_done.
- Run: 'C', halt raised 10 cycles after pc_enable rises → exactly 10 pc_enable cycles; report cycle_count bytes 00 00 00 0B (including the prior step).
- Pipeline reset: 'R' → pc_reset one-cycle pulse, tx 0x52; a following 'S' reports cycle_count 00 00 00 01.
- Unknown byte 0x7A, then 'S' with halt=1 → no outputs for 0x7A; step produces no pc_enable, report cycle_count unchanged.
- Reset after 2 bytes of a load word → IDLE with all outputs 0; a new 'L' N=1 writes at addr 0 with only the new bytes.
